// File: rtl/full_adder_4bit_pkg.sv
// Shared definitions for the registered 4-bit adder stage.
package adder_pkg;

    // Operand/sum width; the block is built and checked only at 4 bits.
    localparam int WIDTH = 4;

    typedef logic [WIDTH-1:0] word_t;

    localparam word_t ZERO_WORD = '0;

    // Signed overflow: operands share a sign and the result sign differs from it.
    function automatic logic calc_ovf(input word_t op_a, input word_t op_b, input word_t sum);
        return (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
    endfunction

    // Zero flag looks at the sum bits only; the carry-out is deliberately ignored.
    function automatic logic calc_zero(input word_t sum);
        return (sum == ZERO_WORD);
    endfunction

endpackage

// File: rtl/full_adder_4bit_if.sv
// Operand/result bundle for the registered adder stage.
interface full_adder_4bit_if;
    import adder_pkg::*;

    word_t a;
    word_t b;
    logic  cin;
    logic  in_valid;
    word_t s;
    logic  cout;
    logic  ovf;
    logic  zero;
    logic  out_valid;

    // Producer side: drives operands, observes registered results.
    modport master (
        output a, b, cin, in_valid,
        input  s, cout, ovf, zero, out_valid
    );

    // Adder side: consumes operands, drives registered results.
    modport slave (
        input  a, b, cin, in_valid,
        output s, cout, ovf, zero, out_valid
    );

endinterface

// File: rtl/full_adder_4bit_fa_1bit.sv
// Combinational 1-bit full-adder cell used to build the ripple chain.
module fa_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p_w;

    // Propagate term is shared between the sum and the carry.
    assign p_w = a ^ b;
    assign s   = p_w ^ ci;
    assign co  = (a & b) | (ci & p_w);

endmodule

// File: rtl/full_adder_4bit.sv
// Registered 4-bit adder: ripple-carry sum plus a one-cycle output/flag register.
module full_adder_4bit
    import adder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    full_adder_4bit_if.slave   bus
);

    logic [WIDTH:0] carry_w;
    word_t          sum_w;
    logic           ovf_w;
    logic           zero_w;

    word_t s_q,    s_d;
    logic  cout_q, cout_d;
    logic  ovf_q,  ovf_d;
    logic  zero_q, zero_d;
    logic  vld_q,  vld_d;

    assign carry_w[0] = bus.cin;

    // Ripple chain: each cell takes the previous carry and hands its own onward.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        fa_1bit u_fa (
            .a  (bus.a[i]),
            .b  (bus.b[i]),
            .ci (carry_w[i]),
            .s  (sum_w[i]),
            .co (carry_w[i+1])
        );
    end

    assign ovf_w  = calc_ovf(bus.a, bus.b, sum_w);
    assign zero_w = calc_zero(sum_w);

    // Next-state: capture a new result on valid, otherwise hold the last one.
    always_comb begin
        s_d    = s_q;
        cout_d = cout_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        vld_d  = bus.in_valid;
        if (bus.in_valid) begin
            s_d    = sum_w;
            cout_d = carry_w[WIDTH];
            ovf_d  = ovf_w;
            zero_d = zero_w;
        end
    end

    // Output register; reset clears everything, including any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q    <= ZERO_WORD;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = vld_q;

endmodule

// File: tb/tb_full_adder_4bit.sv
// Scoreboard bench for the registered 4-bit adder.
module tb_full_adder_4bit;
    import adder_pkg::*;

    typedef struct packed {
        logic [3:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
    } exp_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        exp_t       e;
    } vec_t;

    logic clk;
    logic rst_n;

    full_adder_4bit_if bus_if ();

    full_adder_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t held;
    int   checks = 0;
    int   errors = 0;

    task automatic check1(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pop and compare on every presented result; otherwise outputs must hold.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus_if.out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: out_valid=1 with empty queue s=%h at %0t", bus_if.s, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check1("sum",  bus_if.s, e.s);
                    check1("cout", {3'b0, bus_if.cout}, {3'b0, e.cout});
                    check1("ovf",  {3'b0, bus_if.ovf},  {3'b0, e.ovf});
                    check1("zero", {3'b0, bus_if.zero}, {3'b0, e.zero});
                    held = e;
                end
            end else begin
                check1("out_valid_low", {3'b0, bus_if.out_valid}, 4'h0);
                check1("hold_sum",  bus_if.s, held.s);
                check1("hold_cout", {3'b0, bus_if.cout}, {3'b0, held.cout});
                check1("hold_ovf",  {3'b0, bus_if.ovf},  {3'b0, held.ovf});
                check1("hold_zero", {3'b0, bus_if.zero}, {3'b0, held.zero});
            end
        end
    end

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic v, input exp_t e);
        @(posedge clk);
        #1;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = c;
        bus_if.in_valid = v;
        if (v) exp_q.push_back(e);
    endtask

    localparam int NVEC = 8;
    vec_t vecs [NVEC];

    initial begin
        exp_t nul;
        nul  = '0;
        held = '0;
        // {a, b, cin, {s, cout, ovf, zero}} computed by hand
        vecs[0] = {4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[1] = {4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};
        vecs[2] = {4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1};
        vecs[3] = {4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0};
        vecs[4] = {4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0};
        vecs[5] = {4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 1'b0, 1'b0};
        vecs[6] = {4'h5, 4'hB, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1};
        vecs[7] = {4'h4, 4'h4, 1'b0, 4'h8, 1'b0, 1'b1, 1'b0};

        bus_if.a        = '0;
        bus_if.b        = '0;
        bus_if.cin      = 1'b0;
        bus_if.in_valid = 1'b0;
        rst_n           = 1'b0;
        #1;
        check1("reset_sum", bus_if.s, 4'h0);
        check1("reset_valid", {3'b0, bus_if.out_valid}, 4'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed vectors, back to back
        for (int i = 0; i < NVEC; i++)
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, vecs[i].e);

        // Hold: 2+3 then an invalid cycle with different operands
        drive(4'h2, 4'h3, 1'b0, 1'b1, {4'h5, 1'b0, 1'b0, 1'b0});
        drive(4'hA, 4'hA, 1'b0, 1'b0, nul);
        drive(4'hA, 4'hA, 1'b1, 1'b0, nul);

        // Exhaustive sweep against a 5-bit arithmetic reference
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int ic = 0; ic < 2; ic++) begin
                    logic [4:0] t;
                    logic [3:0] va, vb;
                    exp_t e;
                    va = 4'(ia);
                    vb = 4'(ib);
                    t  = 5'(ia) + 5'(ib) + 5'(ic);
                    e.s    = t[3:0];
                    e.cout = t[4];
                    e.ovf  = (va[3] == vb[3]) && (t[3] != va[3]);
                    e.zero = (t[3:0] == 4'h0);
                    drive(va, vb, 1'(ic), 1'b1, e);
                end

        // Reset while an operation is in flight
        drive(4'h0, 4'h0, 1'b0, 1'b0, nul);
        drive(4'h5, 4'h3, 1'b0, 1'b1, {4'h8, 1'b0, 1'b1, 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check1("rst_mid_sum",   bus_if.s, 4'h0);
        check1("rst_mid_cout",  {3'b0, bus_if.cout}, 4'h0);
        check1("rst_mid_ovf",   {3'b0, bus_if.ovf},  4'h0);
        check1("rst_mid_zero",  {3'b0, bus_if.zero}, 4'h0);
        check1("rst_mid_valid", {3'b0, bus_if.out_valid}, 4'h0);
        exp_q.delete();
        held = '0;
        bus_if.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        check1("rst_held_sum",   bus_if.s, 4'h0);
        check1("rst_held_valid", {3'b0, bus_if.out_valid}, 4'h0);
        #3 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Drain: all expected results must have been observed
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
